// File: rtl/mul_seq.sv
// mul_seq: iterative radix-2 shift-add multiplier for MUL / UMULL / SMULL.
// Signed operands are reduced to magnitudes on start; the sign is re-applied
// once, in FIX, so the RUN datapath is purely unsigned.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | one shift-add step per cycle, WIDTH steps
//   FIX   | apply sign, load result words and flags
//   DONE  | done pulse; start accepted here for back-to-back operation
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result32,
  output logic [WIDTH-1:0] Result64,
  output logic [1:0]       MulFlags
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   r32_q, r32_d;
  logic [WIDTH-1:0]   r64_q, r64_d;
  logic [1:0]         flags_q, flags_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic               flag_n;
  logic               flag_z;

  // Operand magnitudes, one shift-add step and the sign-corrected product.
  always_comb begin
    signed_op = (op == 2'b10);
    // -2^(W-1) negates to itself, which read as unsigned is the right magnitude.
    a_mag     = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    step_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    prod_fix  = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    if (op_q == 2'b00) begin
      flag_n = prod_fix[WIDTH-1];
      flag_z = (prod_fix[WIDTH-1:0] == {WIDTH{1'b0}});
    end else begin
      flag_n = prod_fix[2*WIDTH-1];
      flag_z = (prod_fix == {(2*WIDTH){1'b0}});
    end
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    r32_d    = r32_q;
    r64_d    = r64_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          op_d     = op;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Carry out of the upper-half add becomes the new MSB after the shift.
        acc_d    = {step_sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        r32_d   = prod_fix[WIDTH-1:0];
        r64_d   = prod_fix[2*WIDTH-1:WIDTH];
        flags_d = {flag_n, flag_z};
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r32_q    <= '0;
      r64_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      r32_q    <= r32_d;
      r64_q    <= r64_d;
      flags_q  <= flags_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Result32 = r32_q;
  assign Result64 = r64_q;
  assign MulFlags = flags_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: a cycle-level behavioural model checked on every negedge,
// plus directed operations with literal expected products.
module tb_mul_seq;

  localparam int W = 32;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] Result32;
  logic [31:0] Result64;
  logic [1:0]  MulFlags;

  int n_cmp = 0;
  int n_err = 0;

  mul_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .Result32 (Result32),
    .Result64 (Result64),
    .MulFlags (MulFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
    longint sx, sy;
    if (o == 2'b10) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [1:0] ref_flags(input logic [1:0] o, input logic [63:0] p);
    if (o == 2'b00) return {p[31], p[31:0] == 32'b0};
    return {p[63], p == 64'b0};
  endfunction

  // Model: an accepted start produces busy for 33 cycles, then a done cycle
  // in which the new product appears; outputs otherwise hold.
  bit          m_active = 0;
  int          m_k      = 0;
  logic [63:0] m_prod   = '0;
  logic [1:0]  m_flags  = '0;
  logic        e_busy   = 0;
  logic        e_done   = 0;
  logic [31:0] e_r32    = '0;
  logic [31:0] e_r64    = '0;
  logic [1:0]  e_f      = '0;

  always @(posedge clk or negedge reset) begin : model
    bit accept;
    if (!reset) begin
      m_active = 0; m_k = 0;
      e_busy = 0; e_done = 0; e_r32 = '0; e_r64 = '0; e_f = '0;
    end else begin
      accept = !m_active && start;
      e_done = 0;
      if (m_active) begin
        m_k++;
        if (m_k == 33) begin
          m_active = 0; e_busy = 0; e_done = 1;
          e_r32 = m_prod[31:0]; e_r64 = m_prod[63:32]; e_f = m_flags;
        end
      end
      if (accept) begin
        m_active = 1; m_k = 0; e_busy = 1;
        m_prod   = ref_prod(op, a, b);
        m_flags  = ref_flags(op, m_prod);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("Result32", 64'(Result32), 64'(e_r32));
    chk("Result64", 64'(Result64), 64'(e_r64));
    chk("MulFlags", 64'(MulFlags), 64'(e_f));
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the start edge (or n0 negedges later).
  task automatic wait_done(input int n0, output int n, output int nbusy);
    n = n0;
    nbusy = busy ? 1 : 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  task automatic run_chk(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] ep, input logic [1:0] ef);
    int n, nb;
    launch(o, x, y);
    wait_done(0, n, nb);
    chk({nm, "_latency"}, 64'(n), 64'd33);
    chk({nm, "_r64"}, 64'(Result64), 64'(ep[63:32]));
    chk({nm, "_r32"}, 64'(Result32), 64'(ep[31:0]));
    chk({nm, "_flags"}, 64'(MulFlags), 64'(ef));
  endtask

  initial begin : stim
    int n, nb;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_r32", 64'(Result32), 64'd0);
    chk("reset_flags", 64'(MulFlags), 64'd0);
    reset = 1'b1;

    // UMULL all-ones, with busy duration.
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, n, nb);
    chk("umull_ff_latency", 64'(n), 64'd33);
    chk("umull_ff_busycycles", 64'(nb), 64'd33);
    chk("umull_ff_r64", 64'(Result64), 64'hFFFF_FFFE);
    chk("umull_ff_r32", 64'(Result32), 64'h0000_0001);
    chk("umull_ff_flags", 64'(MulFlags), 64'(2'b10));

    // SMULL sign corners.
    run_chk("smull_min", 2'b10, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2'b00);
    run_chk("smull_m3x5", 2'b10, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 2'b10);
    run_chk("smull_m1m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 2'b00);
    run_chk("smull_zero_neg", 2'b10, 32'h0, 32'hFFFF_FFF0, 64'h0, 2'b01);
    run_chk("op11_as_umull", 2'b11, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 2'b00);

    // MUL flags.
    run_chk("mul_7x6", 2'b00, 32'd7, 32'd6, 64'h2A, 2'b00);
    run_chk("mul_zero", 2'b00, 32'd0, 32'h1234_5678, 64'h0, 2'b01);
    run_chk("mul_hi_only", 2'b00, 32'h1_0000, 32'h1_0000, 64'h1_0000_0000, 2'b01);
    run_chk("mul_neg_low", 2'b00, 32'hFFFF_FFFF, 32'd3, 64'h2_FFFF_FFFD, 2'b10);

    // Ignored start and operand changes mid-run.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h1_0000; b = 32'h3_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hFFFF_FFFF; b = 32'd7;
    @(negedge clk);
    start = 1'b0; a = 32'd5; b = 32'd9;
    wait_done(11, n, nb);
    chk("ignore_latency", 64'(n), 64'd33);
    chk("ignore_r64", 64'(Result64), 64'd3);
    chk("ignore_r32", 64'(Result32), 64'd0);
    @(negedge clk);
    chk("ignore_no_second_done", 64'(done), 64'd0);

    // Back-to-back: MUL 7x6, then UMULL 3x4 started in the DONE cycle.
    launch(2'b00, 32'd7, 32'd6);
    wait_done(0, n, nb);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_started", 64'(busy), 64'd1);
    chk("b2b_hold_early", 64'(Result32), 64'h2A);
    repeat (20) @(negedge clk);
    chk("b2b_hold_mid", 64'(Result32), 64'h2A);
    wait_done(20, n, nb);
    chk("b2b_latency", 64'(n), 64'd33);
    chk("b2b_r32", 64'(Result32), 64'd12);
    chk("b2b_r64", 64'(Result64), 64'd0);

    // Reset mid-run, then a fresh SMULL.
    launch(2'b10, 32'h7FFF_FFFF, 32'd3);
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_r32", 64'(Result32), 64'd0);
    chk("rst_r64", 64'(Result64), 64'd0);
    chk("rst_flags", 64'(MulFlags), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b1; op = 2'b10; a = 32'd2; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, n, nb);
    chk("post_rst_latency", 64'(n), 64'd33);
    chk("post_rst_r64", 64'(Result64), 64'hFFFF_FFFF);
    chk("post_rst_r32", 64'(Result32), 64'hFFFF_FFFE);
    chk("post_rst_flags", 64'(MulFlags), 64'(2'b10));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative 32×32 multiplier for the multicycle ARM core, covering MUL, UMULL and SMULL. It sits beside the ALU and consumes the same SrcA/SrcB operands. It produces the low and high result words that feed the 32-bit and 64-bit register-file write ports. The main FSM starts it and waits for `done` before issuing the register writeback.

## Interface

**Parameters**
- `WIDTH`, default 32: operand width. The product is 2·WIDTH bits.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: reset. One clock; reset is asynchronous and active-low (asserted when 0).
- `start`, input, 1: request a multiply. Sampled only in IDLE or DONE.
- `op`, input, 2: operation. 00 = MUL (low word only), 01 = UMULL, 10 = SMULL, 11 = treated as UMULL.
- `a`, input, WIDTH: multiplicand (SrcA).
- `b`, input, WIDTH: multiplier (SrcB).
- `busy`, output, 1: high in RUN and FIX.
- `done`, output, 1: one-cycle pulse (state DONE); results are valid from this cycle on.
- `Result32`, output, WIDTH: product[WIDTH-1:0].
- `Result64`, output, WIDTH: product[2·WIDTH-1:WIDTH].
- `MulFlags`, output, 2: {N, Z}.

## Operation

**States:** IDLE, RUN, FIX, DONE.

**IDLE / DONE with `start`=1 → RUN.** On this edge the block:
- latches `op`;
- latches |a| and |b| (two's-complement magnitude when `op`=10, raw otherwise);
- latches `neg` = a[W-1]^b[W-1] when `op`=10, else 0;
- clears the accumulator (2·WIDTH) and sets `count`=0.

**IDLE / DONE with `start`=0:**
- IDLE holds.
- DONE → IDLE.

**RUN, one radix-2 shift-add step per cycle:**
- If multiplier LSB = 1, add multiplicand into the upper accumulator half, with carry kept.
- Shift {carry, accumulator} right by 1; shift the multiplier right by 1.
- Increment `count`. After the step with `count`=WIDTH-1, go to FIX.

**FIX:**
- If `neg`, two's-complement the 2·WIDTH product.
- Load `Result32`, `Result64` and `MulFlags`.
- Go to DONE.

**DONE:** `done`=1 for exactly this cycle. `start` sampled here is accepted, so back-to-back operations are allowed.

**Width and sign rules:**
- |−2^(W-1)| = 2^(W-1) is held unsigned in WIDTH bits, so no overflow occurs.
- A product magnitude of 0 with `neg`=1 yields 0.

**Flags:**
- Long ops (01, 10, 11): N = product[2W-1]; Z = (product == 0).
- MUL: N = product[W-1]; Z = (product[W-1:0] == 0). `Result64` still carries the upper half; the controller ignores it for MUL.

**Operand changes:** changes on `a`, `b` or `op` after the start edge have no effect.

**`start` while busy:** ignored, with no queuing.

**Output hold:** `Result32`, `Result64` and `MulFlags` hold their values until the next FIX. They do not clear in IDLE.

**Reset:**
- When `reset` goes 0, all state clears immediately, asynchronously: state = IDLE, `busy`=0, `done`=0, `Result32`=0, `Result64`=0, `MulFlags`=0, and internal registers = 0.
- Reset mid-RUN aborts the operation; no `done` is produced.

## Timing

- **Start edge:** `start` is sampled at rising edge E0 (state IDLE or DONE).
- **RUN:** `busy`=1 from after E0. RUN occupies edges E1…E(WIDTH).
- **FIX:** occupies the cycle after E(WIDTH). Results are registered at edge E(WIDTH+1).
- **DONE:** `done`=1 during the cycle after E(WIDTH+1). For WIDTH=32, `done` goes high 33 cycles after the start edge.
- **`busy`:** deasserts in the same cycle `done` asserts.
- **Throughput:** one multiply per WIDTH+2 cycles when `start` is asserted in DONE.
- **Latency:** fixed and data-independent; there is no early termination.
- **Reset deassertion:** `reset` rising is synchronized externally. The first `start` is accepted at the first clock edge after deassertion.

## Test plan

1. **UMULL, all-ones operands.** `op`=01, a=b=0xFFFFFFFF → `Result64`=0xFFFFFFFE, `Result32`=0x00000001, N=1, Z=0, `done` exactly 33 cycles after the start edge, `busy` high for 32+1 cycles.
2. **SMULL sign corners.**
   - a=b=0x80000000 → 0x40000000_00000000, N=0.
   - a=0xFFFFFFFD (−3), b=5 → 0xFFFFFFFF_FFFFFFF1, N=1.
   - a=b=0xFFFFFFFF → 0x00000000_00000001.
3. **MUL flags.**
   - a=7, b=6 → `Result32`=0x2A, N=0, Z=0.
   - a=0, b=0x12345678 → `Result32`=0, Z=1.
   - a=0x10000, b=0x10000 → `Result32`=0, Z=1, `Result64`=1.
4. **Ignored `start` and operand changes.** Pulse `start` with new operands at RUN cycle 10, and change `a`/`b` mid-run → original result is produced, with a single `done` at the original time.
5. **Back-to-back.** Assert `start` in the DONE cycle with UMULL 3×4 → second `done` 33 cycles later with `Result32`=12; the first result is visible until the second FIX.
6. **Reset mid-run.** `reset`=0 at RUN cycle 15 → all outputs 0 immediately, no `done` pulse; a fresh `start` after release (SMULL 2×−1) returns 0xFFFFFFFF_FFFFFFFE.
